// File: rtl/subservient_debug_cmd.sv
// rtl/subservient_debug_cmd.sv - byte-command debug bridge from a host serial link to a Wishbone master
module subservient_debug_cmd #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_debug_mode,
    output logic [31:0] o_wb_dbg_adr,
    output logic [31:0] o_wb_dbg_dat,
    output logic [3:0]  o_wb_dbg_sel,
    output logic        o_wb_dbg_we,
    output logic        o_wb_dbg_stb,
    input  logic [31:0] i_wb_dbg_rdt,
    input  logic        i_wb_dbg_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    localparam logic [7:0] OP_ENTER = 8'h01;
    localparam logic [7:0] OP_EXIT  = 8'h02;
    localparam logic [7:0] OP_WRITE = 8'h10;
    localparam logic [7:0] OP_READ  = 8'h20;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    // Last value of the strobe-cycle counter before the access is abandoned.
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic        we_q, we_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        stb_q, stb_d;
    logic [15:0] tmr_q, tmr_d;
    logic [31:0] resp_q, resp_d;
    logic [1:0]  resp_cnt_q, resp_cnt_d;

    logic rx_fire;
    logic tx_fire;

    assign o_rx_ready   = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign o_tx_valid   = (state_q == S_RESP);
    assign o_tx_data    = resp_q[7:0];
    assign o_debug_mode = mode_q;
    assign o_wb_dbg_adr = adr_q;
    assign o_wb_dbg_dat = dat_q;
    assign o_wb_dbg_sel = 4'hF;
    assign o_wb_dbg_we  = we_q;
    assign o_wb_dbg_stb = stb_q;

    assign rx_fire = i_rx_valid && o_rx_ready;
    assign tx_fire = o_tx_valid && i_tx_ready;

    // Register all state; reset aborts any bus access or response in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            we_q       <= 1'b0;
            idx_q      <= 2'd0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            stb_q      <= 1'b0;
            tmr_q      <= 16'd0;
            resp_q     <= 32'd0;
            resp_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            stb_q      <= stb_d;
            tmr_q      <= tmr_d;
            resp_q     <= resp_d;
            resp_cnt_q <= resp_cnt_d;
        end
    end

    // Command decode, byte collection, bus sequencing and response shifting.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        we_d       = we_q;
        idx_d      = idx_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        stb_d      = stb_q;
        tmr_d      = tmr_q;
        resp_d     = resp_q;
        resp_cnt_d = resp_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    idx_d      = 2'd0;
                    resp_cnt_d = 2'd0;
                    case (i_rx_data)
                        OP_ENTER: begin
                            mode_d  = 1'b1;
                            resp_d  = {24'd0, RSP_ACK};
                            state_d = S_RESP;
                        end
                        OP_EXIT: begin
                            mode_d  = 1'b0;
                            resp_d  = {24'd0, RSP_ACK};
                            state_d = S_RESP;
                        end
                        OP_WRITE: begin
                            we_d    = 1'b1;
                            state_d = S_ADDR;
                        end
                        OP_READ: begin
                            we_d    = 1'b0;
                            state_d = S_ADDR;
                        end
                        default: begin
                            resp_d  = {24'd0, RSP_NAK};
                            state_d = S_RESP;
                        end
                    endcase
                end
            end

            S_ADDR: begin
                if (rx_fire) begin
                    // The word-aligned address never carries the two low bits.
                    adr_d[{idx_q, 3'b000} +: 8] = (idx_q == 2'd0) ? {i_rx_data[7:2], 2'b00} : i_rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (we_q) begin
                            state_d = S_DATA;
                        end else if (mode_q) begin
                            state_d = S_BUS;
                        end else begin
                            resp_d     = {24'd0, RSP_NAK};
                            resp_cnt_d = 2'd0;
                            state_d    = S_RESP;
                        end
                    end
                end
            end

            S_DATA: begin
                if (rx_fire) begin
                    dat_d[{idx_q, 3'b000} +: 8] = i_rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (mode_q) begin
                            state_d = S_BUS;
                        end else begin
                            resp_d     = {24'd0, RSP_NAK};
                            resp_cnt_d = 2'd0;
                            state_d    = S_RESP;
                        end
                    end
                end
            end

            S_BUS: begin
                if (!stb_q) begin
                    // First BUS cycle: strobe goes out on the next edge.
                    stb_d = 1'b1;
                    tmr_d = 16'd0;
                end else if (i_wb_dbg_ack) begin
                    stb_d   = 1'b0;
                    state_d = S_RESP;
                    if (we_q) begin
                        resp_d     = {24'd0, RSP_ACK};
                        resp_cnt_d = 2'd0;
                    end else begin
                        resp_d     = i_wb_dbg_rdt;
                        resp_cnt_d = 2'd3;
                    end
                end else if (tmr_q == TMO_LAST) begin
                    stb_d      = 1'b0;
                    resp_d     = {24'd0, RSP_NAK};
                    resp_cnt_d = 2'd0;
                    state_d    = S_RESP;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end

            S_RESP: begin
                if (tx_fire) begin
                    if (resp_cnt_q == 2'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        resp_d     = {8'd0, resp_q[31:8]};
                        resp_cnt_d = resp_cnt_q - 2'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_subservient_debug_cmd.sv
// tb/tb_subservient_debug_cmd.sv - self-checking bench for subservient_debug_cmd
module tb_subservient_debug_cmd;

    localparam int TMO = 8;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_debug_mode;
    logic [31:0] o_wb_dbg_adr;
    logic [31:0] o_wb_dbg_dat;
    logic [3:0]  o_wb_dbg_sel;
    logic        o_wb_dbg_we;
    logic        o_wb_dbg_stb;
    logic [31:0] i_wb_dbg_rdt;
    logic        i_wb_dbg_ack;

    subservient_debug_cmd #(.ACK_TIMEOUT(TMO)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_debug_mode (o_debug_mode),
        .o_wb_dbg_adr (o_wb_dbg_adr),
        .o_wb_dbg_dat (o_wb_dbg_dat),
        .o_wb_dbg_sel (o_wb_dbg_sel),
        .o_wb_dbg_we  (o_wb_dbg_we),
        .o_wb_dbg_stb (o_wb_dbg_stb),
        .i_wb_dbg_rdt (i_wb_dbg_rdt),
        .i_wb_dbg_ack (i_wb_dbg_ack)
    );

    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  txq[$];
    int          strobes    = 0;
    int          stb_cycles = 0;
    int          stb_run    = 0;
    logic        prev_stb   = 1'b0;
    logic [31:0] rec_adr    = 32'd0;
    logic [31:0] rec_dat    = 32'd0;
    logic        rec_we     = 1'b0;
    logic [3:0]  rec_sel    = 4'd0;
    int          ack_delay  = 0;
    logic [31:0] cur_rdt    = 32'd0;
    logic        spur_en    = 1'b0;
    logic        held_valid = 1'b0;
    logic [7:0]  held_data  = 8'd0;
    logic        model_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Host receive side: random back-pressure, byte capture, hold-stability check.
    always @(negedge i_clk) begin
        i_tx_ready = 1'($urandom_range(0, 1));
        if (o_tx_valid && held_valid)
            check("tx_hold", {24'd0, o_tx_data}, {24'd0, held_data});
        if (o_tx_valid && i_tx_ready) begin
            txq.push_back(o_tx_data);
            held_valid = 1'b0;
        end else if (o_tx_valid) begin
            held_valid = 1'b1;
            held_data  = o_tx_data;
        end else begin
            held_valid = 1'b0;
        end
    end

    // Wishbone slave: records each strobe, checks stability, acks on a chosen cycle.
    always @(negedge i_clk) begin
        if (o_wb_dbg_stb) begin
            stb_cycles++;
            if (!prev_stb) begin
                strobes++;
                stb_run = 1;
                rec_adr = o_wb_dbg_adr;
                rec_dat = o_wb_dbg_dat;
                rec_we  = o_wb_dbg_we;
                rec_sel = o_wb_dbg_sel;
            end else begin
                stb_run++;
                check("adr_stable", o_wb_dbg_adr, rec_adr);
                check("dat_stable", o_wb_dbg_dat, rec_dat);
                check("we_stable", {31'd0, o_wb_dbg_we}, {31'd0, rec_we});
            end
            if (stb_run == ack_delay) begin
                i_wb_dbg_ack = 1'b1;
                i_wb_dbg_rdt = cur_rdt;
            end else begin
                i_wb_dbg_ack = 1'b0;
                i_wb_dbg_rdt = $urandom;
            end
        end else begin
            stb_run      = 0;
            i_wb_dbg_ack = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
            i_wb_dbg_rdt = $urandom;
        end
        prev_stb = o_wb_dbg_stb;
    end

    // Called at a negedge; returns at a negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int t;
        repeat ($urandom_range(0, 2)) @(negedge i_clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        t = 0;
        while (!o_rx_ready && t < 300) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 300) check("rx_ready_timeout", 32'd0, 32'd1);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_rx_data  = $urandom;
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] dat,
                          input int delay, input logic [31:0] rdt);
        logic [7:0] exp_q[$];
        logic       exp_acc;
        logic       ok;
        int         t;
        exp_acc    = 1'b0;
        ok         = (delay >= 1) && (delay <= TMO);
        txq        = {};
        strobes    = 0;
        stb_cycles = 0;
        ack_delay  = delay;
        cur_rdt    = rdt;

        case (op)
            8'h01: begin model_mode = 1'b1; exp_q.push_back(8'h06); end
            8'h02: begin model_mode = 1'b0; exp_q.push_back(8'h06); end
            8'h10: begin
                exp_acc = model_mode;
                exp_q.push_back((model_mode && ok) ? 8'h06 : 8'h15);
            end
            8'h20: begin
                exp_acc = model_mode;
                if (model_mode && ok)
                    for (int i = 0; i < 4; i++) exp_q.push_back(rdt[8*i +: 8]);
                else
                    exp_q.push_back(8'h15);
            end
            default: exp_q.push_back(8'h15);
        endcase

        send_byte(op);
        if (op == 8'h10 || op == 8'h20)
            for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8]);
        if (op == 8'h10)
            for (int i = 0; i < 4; i++) send_byte(dat[8*i +: 8]);

        t = 0;
        while (txq.size() < exp_q.size() && t < 400) begin
            @(negedge i_clk);
            t++;
        end
        repeat (3) @(negedge i_clk);

        check("tx_count", txq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < txq.size(); i++)
            check("tx_byte", {24'd0, txq[i]}, {24'd0, exp_q[i]});
        check("strobes", strobes, {31'd0, exp_acc});
        if (exp_acc) begin
            check("wb_adr", rec_adr, {adr[31:2], 2'b00});
            check("wb_we", {31'd0, rec_we}, {31'd0, (op == 8'h10)});
            check("wb_sel", {28'd0, rec_sel}, 32'hF);
            check("stb_cycles", stb_cycles, ok ? delay : TMO);
            if (op == 8'h10) check("wb_dat", rec_dat, dat);
        end
        check("debug_mode", {31'd0, o_debug_mode}, {31'd0, model_mode});
        check("back_idle", {31'd0, o_rx_ready}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rop;
        int         t;
        i_rst        = 1'b1;
        i_rx_data    = 8'd0;
        i_rx_valid   = 1'b0;
        i_tx_ready   = 1'b0;
        i_wb_dbg_rdt = 32'd0;
        i_wb_dbg_ack = 1'b0;
        repeat (3) @(negedge i_clk);

        check("rst_rx_ready", {31'd0, o_rx_ready}, 32'd1);
        check("rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
        check("rst_stb", {31'd0, o_wb_dbg_stb}, 32'd0);
        check("rst_we", {31'd0, o_wb_dbg_we}, 32'd0);
        check("rst_mode", {31'd0, o_debug_mode}, 32'd0);
        check("rst_adr", o_wb_dbg_adr, 32'd0);
        check("rst_dat", o_wb_dbg_dat, 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Mode entry/exit, write, read, NAK paths and timeout.
        do_cmd(8'h01, 32'd0, 32'd0, 0, 32'd0);
        do_cmd(8'h02, 32'd0, 32'd0, 0, 32'd0);
        do_cmd(8'h01, 32'd0, 32'd0, 0, 32'd0);
        do_cmd(8'h10, 32'h01020304, 32'hDEADBEEF, 3, 32'd0);
        do_cmd(8'h20, 32'h00001000, 32'd0, 2, 32'h12345678);
        do_cmd(8'h55, 32'd0, 32'd0, 0, 32'd0);
        do_cmd(8'h20, 32'hCAFEF00F, 32'd0, 0, 32'd0);
        do_cmd(8'h10, 32'h00000013, 32'h0BADF00D, 8, 32'd0);
        do_cmd(8'h20, 32'h00000020, 32'd0, 9, 32'h11111111);
        do_cmd(8'h02, 32'd0, 32'd0, 0, 32'd0);
        do_cmd(8'h20, 32'h00002000, 32'd0, 1, 32'hAAAA5555);
        do_cmd(8'h10, 32'h00003000, 32'h12121212, 1, 32'd0);

        // Randomised commands with spurious acks outside the strobe.
        spur_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: rop = 8'h01;
                1: rop = 8'h02;
                2, 3: rop = 8'h10;
                4: rop = 8'h20;
                default: rop = 8'($urandom);
            endcase
            if (n % 7 == 0) rop = 8'h01;
            do_cmd(rop, $urandom, $urandom, $urandom_range(0, 10), $urandom);
        end
        spur_en = 1'b0;

        // Reset in the middle of a read access.
        do_cmd(8'h01, 32'd0, 32'd0, 0, 32'd0);
        txq       = {};
        ack_delay = 0;
        send_byte(8'h20);
        for (int i = 0; i < 4; i++) send_byte(8'h40);
        t = 0;
        while (!o_wb_dbg_stb && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        check("stb_seen_before_reset", {31'd0, o_wb_dbg_stb}, 32'd1);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        model_mode = 1'b0;
        check("mid_rst_stb", {31'd0, o_wb_dbg_stb}, 32'd0);
        check("mid_rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
        check("mid_rst_mode", {31'd0, o_debug_mode}, 32'd0);
        check("mid_rst_rx_ready", {31'd0, o_rx_ready}, 32'd1);
        i_rst = 1'b0;
        repeat (20) @(negedge i_clk);
        check("no_tx_after_rst", txq.size(), 32'd0);
        check("no_stb_after_rst", {31'd0, o_wb_dbg_stb}, 32'd0);
        do_cmd(8'h02, 32'd0, 32'd0, 0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
